// File: rtl/ex_branch_ctrl.sv
// ============================================================================
//  Module      : ex_branch_ctrl
//  Description : EX-stage control-transfer resolver. Decides taken/not-taken
//                for branch/jump ops, issues a one-cycle registered PC
//                redirect and holds BranchBubble high for FLUSH_CYCLES
//                non-stalled cycles to squash wrong-path instructions.
//                Optional statistics counters are built only when the
//                macro BRANCH_STATS_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_branch_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        ex_branch_beq,
  input  logic        ex_branch_bne,
  input  logic        ex_bltz,
  input  logic        ex_blez,
  input  logic        ex_bgez,
  input  logic        ex_bgtz,
  input  logic        ex_jump,
  input  logic        ex_jal,
  input  logic        ex_jalr,
  input  logic [31:0] ex_busA,
  input  logic [31:0] ex_busB,
  input  logic [29:0] ex_PC_plus_4,
  input  logic [31:0] ex_imm32,
  input  logic [25:0] ex_target,
  input  logic [29:0] ex_jalpc,
  output logic        BranchBubble,
  output logic        redirect_valid,
  output logic [29:0] redirect_pc,
  output logic [31:0] stat_taken,
  output logic [31:0] stat_resolved
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic              taken;
  logic              any_flag;
  logic              start;
  logic              resolve;
  logic [29:0]       target;
  logic              a_eq_b;
  logic              a_zero;

  // Offset bits above the 30-bit word address space are intentionally dropped.
  logic unused_imm_hi;
  assign unused_imm_hi = &{1'b0, ex_imm32[31:30]};

  assign a_eq_b   = (ex_busA == ex_busB);
  assign a_zero   = (ex_busA == 32'd0);
  assign any_flag = ex_jalr | ex_jal | ex_jump | ex_branch_beq | ex_branch_bne |
                    ex_bltz | ex_blez | ex_bgez | ex_bgtz;

  // Prioritised taken decision and target selection for the op in EX.
  always_comb begin
    taken  = 1'b0;
    target = ex_PC_plus_4 + ex_imm32[29:0];
    if (ex_jalr) begin
      taken  = 1'b1;
      target = ex_jalpc;
    end else if (ex_jal || ex_jump) begin
      taken  = 1'b1;
      target = {ex_PC_plus_4[29:26], ex_target};
    end else if (ex_branch_beq) begin
      taken = a_eq_b;
    end else if (ex_branch_bne) begin
      taken = !a_eq_b;
    end else if (ex_bltz) begin
      taken = ex_busA[31];
    end else if (ex_blez) begin
      taken = ex_busA[31] | a_zero;
    end else if (ex_bgez) begin
      taken = !ex_busA[31];
    end else if (ex_bgtz) begin
      taken = !ex_busA[31] & !a_zero;
    end
  end

  // A control op is only resolved in IDLE with the pipeline moving.
  assign resolve = (state == IDLE) && !stall && any_flag;
  assign start   = resolve && taken;

  // Next-state and flush-counter logic.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = FLUSH;
          cnt_n   = FLUSH_LOAD;
        end
      end
      FLUSH: begin
        if (!stall) begin
          if (cnt == '0) begin
            state_n = IDLE;
          end else begin
            cnt_n = cnt - 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // State, counter and registered outputs; async reset aborts any flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      cnt            <= '0;
      BranchBubble   <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      state          <= state_n;
      cnt            <= cnt_n;
      BranchBubble   <= (state_n == FLUSH);
      redirect_valid <= start;
      if (start) begin
        redirect_pc <= target;
      end
    end
  end

`ifdef BRANCH_STATS_EN
  // Free-running wrap-around statistics counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_taken    <= '0;
      stat_resolved <= '0;
    end else begin
      if (resolve) begin
        stat_resolved <= stat_resolved + 32'd1;
      end
      if (start) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`else
  assign stat_taken    = 32'd0;
  assign stat_resolved = 32'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_branch_ctrl.sv
`default_nettype none

module tb_ex_branch_ctrl;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        ex_branch_beq, ex_branch_bne, ex_bltz, ex_blez, ex_bgez, ex_bgtz;
  logic        ex_jump, ex_jal, ex_jalr;
  logic [31:0] ex_busA, ex_busB, ex_imm32;
  logic [29:0] ex_PC_plus_4, ex_jalpc;
  logic [25:0] ex_target;
  logic        BranchBubble, redirect_valid;
  logic [29:0] redirect_pc;
  logic [31:0] stat_taken, stat_resolved;

  int total = 0;
  int bad   = 0;

  ex_branch_ctrl #(.FLUSH_CYCLES(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .stall(stall),
    .ex_branch_beq(ex_branch_beq), .ex_branch_bne(ex_branch_bne),
    .ex_bltz(ex_bltz), .ex_blez(ex_blez), .ex_bgez(ex_bgez), .ex_bgtz(ex_bgtz),
    .ex_jump(ex_jump), .ex_jal(ex_jal), .ex_jalr(ex_jalr),
    .ex_busA(ex_busA), .ex_busB(ex_busB), .ex_PC_plus_4(ex_PC_plus_4),
    .ex_imm32(ex_imm32), .ex_target(ex_target), .ex_jalpc(ex_jalpc),
    .BranchBubble(BranchBubble), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stat_taken(stat_taken), .stat_resolved(stat_resolved)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_flags();
    ex_branch_beq = 0; ex_branch_bne = 0; ex_bltz = 0; ex_blez = 0;
    ex_bgez = 0; ex_bgtz = 0; ex_jump = 0; ex_jal = 0; ex_jalr = 0;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic rv, input logic bb);
    check({tag, ".rv"}, {31'd0, redirect_valid}, {31'd0, rv});
    check({tag, ".bub"}, {31'd0, BranchBubble}, {31'd0, bb});
  endtask

  // Taken beq (A==B) followed by the two flush cycles.
  task automatic taken_beq(input logic [29:0] pc4, input logic [31:0] imm);
    clear_flags();
    ex_branch_beq = 1; ex_busA = 32'd3; ex_busB = 32'd3;
    ex_PC_plus_4 = pc4; ex_imm32 = imm;
    step();
    clear_flags();
    step();
    step();
  endtask

  // Not-taken bne (A==B).
  task automatic nt_bne();
    clear_flags();
    ex_branch_bne = 1; ex_busA = 32'd9; ex_busB = 32'd9;
    step();
    clear_flags();
  endtask

  initial begin
    rst = 1; stall = 0; clear_flags();
    ex_busA = 0; ex_busB = 0; ex_imm32 = 0; ex_PC_plus_4 = 0;
    ex_jalpc = 0; ex_target = 0;
    #12;
    check_out("reset", 1'b0, 1'b0);
    check("reset.pc", {2'b0, redirect_pc}, 32'd0);
    check("reset.st", stat_taken, 32'd0);
    check("reset.sr", stat_resolved, 32'd0);
    @(negedge clk); rst = 0;

    // 1: beq taken, one redirect pulse, bubble for two cycles
    ex_branch_beq = 1; ex_busA = 5; ex_busB = 5; ex_PC_plus_4 = 30'h100; ex_imm32 = 32'h10;
    step();
    check_out("beq.t1", 1'b1, 1'b1);
    check("beq.pc", {2'b0, redirect_pc}, 32'h110);
    clear_flags();
    step();
    check_out("beq.t2", 1'b0, 1'b1);
    step();
    check_out("beq.t3", 1'b0, 1'b0);
    check("beq.pchold", {2'b0, redirect_pc}, 32'h110);

    // 2: not-taken cases
    ex_branch_bne = 1; ex_busA = 7; ex_busB = 7;
    step();
    check_out("bne.nt", 1'b0, 1'b0);
    clear_flags(); ex_bgtz = 1; ex_busA = 0;
    step();
    check_out("bgtz.nt", 1'b0, 1'b0);
    clear_flags(); ex_blez = 1; ex_busA = 32'd1;
    step();
    check_out("blez.nt", 1'b0, 1'b0);
    check("nt.pchold", {2'b0, redirect_pc}, 32'h110);

    // 3: jump target concatenation
    clear_flags(); ex_jump = 1; ex_target = 26'h0ABCDEF; ex_PC_plus_4 = 30'h3000_0040;
    step();
    check_out("j", 1'b1, 1'b1);
    check("j.pc", {2'b0, redirect_pc}, 32'h30ABCDEF);
    clear_flags(); step(); step();
    check_out("j.end", 1'b0, 1'b0);

    // bltz on negative operand
    ex_bltz = 1; ex_busA = 32'h8000_0000; ex_PC_plus_4 = 30'h200; ex_imm32 = 32'h4;
    step();
    check_out("bltz", 1'b1, 1'b1);
    check("bltz.pc", {2'b0, redirect_pc}, 32'h204);
    clear_flags(); step(); step();

    // conditional target wraps modulo 2^30
    ex_branch_beq = 1; ex_busA = 1; ex_busB = 1; ex_PC_plus_4 = 30'h3FFF_FFFF; ex_imm32 = 32'd2;
    step();
    check("wrap.pc", {2'b0, redirect_pc}, 32'h1);
    clear_flags(); step(); step();

    // jalr beats a simultaneous taken beq
    ex_jalr = 1; ex_jalpc = 30'h1234; ex_branch_beq = 1; ex_busA = 2; ex_busB = 2;
    ex_PC_plus_4 = 30'h40; ex_imm32 = 32'h8;
    step();
    check("prio.pc", {2'b0, redirect_pc}, 32'h1234);
    clear_flags(); step(); step();

    // 4: stall during flush stretches bubble, redirect stays a single pulse
    ex_branch_beq = 1; ex_busA = 4; ex_busB = 4; ex_PC_plus_4 = 30'h500; ex_imm32 = 32'h20;
    step();
    check_out("st.t1", 1'b1, 1'b1);
    check("st.pc", {2'b0, redirect_pc}, 32'h520);
    // keep a taken beq present with a different target; it must be ignored
    ex_imm32 = 32'h40; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("st.hold", 1'b0, 1'b1);
    end
    stall = 0;
    step();
    check_out("st.rel1", 1'b0, 1'b1);
    step();
    check_out("st.rel2", 1'b0, 1'b0);
    check("st.pckeep", {2'b0, redirect_pc}, 32'h520);
    clear_flags();
    step();
    check_out("st.idle", 1'b0, 1'b0);

    // 5: async reset mid-flush
    ex_branch_beq = 1; ex_busA = 6; ex_busB = 6; ex_PC_plus_4 = 30'h600; ex_imm32 = 32'h1;
    step();
    check_out("ar.pre", 1'b1, 1'b1);
    clear_flags();
    #2 rst = 1;
    #1;
    check_out("ar.now", 1'b0, 1'b0);
    check("ar.pc", {2'b0, redirect_pc}, 32'd0);
    @(negedge clk); rst = 0;
    step();
    check_out("ar.after", 1'b0, 1'b0);

    // 6: statistics
    taken_beq(30'h10, 32'h1);
    nt_bne();
    taken_beq(30'h20, 32'h2);
    nt_bne();
    taken_beq(30'h30, 32'h3);
`ifdef BRANCH_STATS_EN
    check("stat.taken", stat_taken, 32'd3);
    check("stat.res", stat_resolved, 32'd5);
    @(negedge clk);
    dut.stat_taken    = 32'hFFFF_FFFF;
    dut.stat_resolved = 32'hFFFF_FFFF;
    taken_beq(30'h40, 32'h4);
    check("stat.wrapt", stat_taken, 32'd0);
    check("stat.wrapr", stat_resolved, 32'd0);
`else
    check("stat.taken", stat_taken, 32'd0);
    check("stat.res", stat_resolved, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
